// File: rtl/fog_param_estimator.sv
`default_nettype none
// ============================================================================
//  Module      : fog_param_estimator
//  Description : Streaming haze-parameter estimator. Computes a per-pixel
//                transmittance from the dark channel (min of R,G,B) and a
//                per-frame atmospheric light estimate (maximum dark channel
//                value, clamped and optionally IIR-smoothed across frames).
//                The video stream is passed through with a fixed latency of
//                4 cycles so the sidebands line up with the pixels.
//  Ports       : pixelclk        - pixel clock, rising edge
//                reset_n         - asynchronous active-low reset
//                i_rgb           - pixel {R[23:16], G[15:8], B[7:0]}
//                i_hsync/i_vsync - sync inputs (vsync active high)
//                i_de            - data enable
//                o_rgb           - i_rgb delayed 4 cycles
//                o_transmittance - per-pixel transmittance aligned to o_rgb
//                o_dark_max      - atmospheric light, constant within a frame
//                o_hsync/o_vsync/o_de - syncs delayed 4 cycles
//                o_frame_valid   - high once a frame estimate was latched
//  Revision    : 1.0 - initial release
// ============================================================================
module fog_param_estimator #(
    parameter int unsigned OMEGA  = 243,
    parameter int unsigned T_MIN  = 26,
    parameter int unsigned A_MIN  = 128,
    parameter int unsigned A_INIT = 255,
    parameter int unsigned SMOOTH = 1
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic [23:0] i_rgb,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    output logic [23:0] o_rgb,
    output logic [7:0]  o_transmittance,
    output logic [7:0]  o_dark_max,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_frame_valid
);

    localparam logic [7:0] c_omega  = 8'(OMEGA);
    localparam logic [7:0] c_t_min  = 8'(T_MIN);
    localparam logic [7:0] c_a_min  = 8'(A_MIN);
    localparam logic [7:0] c_a_init = 8'(A_INIT);

    // ------------------------------------------------------------------
    // Pipeline stage registers
    // ------------------------------------------------------------------
    logic [7:0]  r_s1_m1;
    logic [7:0]  r_s1_b;
    logic [23:0] r_s1_rgb;
    logic        r_s1_hsync, r_s1_vsync, r_s1_de;

    logic [7:0]  r_s2_dark;
    logic [23:0] r_s2_rgb;
    logic        r_s2_hsync, r_s2_vsync, r_s2_de;

    logic [7:0]  r_s3_prod_hi;
    logic [23:0] r_s3_rgb;
    logic        r_s3_hsync, r_s3_vsync, r_s3_de;

    // Frame statistics
    logic [7:0]  r_run_max;
    logic        r_has_pix;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [7:0] w_r, w_g, w_b;
    logic [7:0] w_m1;
    logic [7:0] w_dark;
    logic [7:0] w_t;
    logic [7:0] w_t_clamped;
    logic       w_event;
    logic [7:0] w_pix;
    logic [7:0] w_cand;
    logic [7:0] w_cand_c;
    logic [7:0] w_smooth;
    logic [7:0] w_new_dark_max;
    logic       w_has;

    assign w_r  = i_rgb[23:16];
    assign w_g  = i_rgb[15:8];
    assign w_b  = i_rgb[7:0];
    assign w_m1 = (w_r < w_g) ? w_r : w_g;

    assign w_dark = (r_s1_m1 < r_s1_b) ? r_s1_m1 : r_s1_b;

    // 255 - prod[15:8], clamped from below so the defog divide stays bounded
    assign w_t         = 8'd255 - r_s3_prod_hi;
    assign w_t_clamped = (w_t < c_t_min) ? c_t_min : w_t;

    // Frame boundary: rising edge of vsync seen on the S2/S3 delayed copies,
    // so the decision is aligned with the dark values feeding the maximum.
    assign w_event = r_s2_vsync & ~r_s3_vsync;

    // A pixel arriving at S2 on the edge cycle still belongs to the old frame
    assign w_pix    = r_s2_de ? r_s2_dark : 8'd0;
    assign w_cand   = (r_run_max > w_pix) ? r_run_max : w_pix;
    assign w_cand_c = (w_cand < c_a_min) ? c_a_min : w_cand;
    assign w_has    = r_has_pix | r_s2_de;

    // (3*A + cand) / 4 with truncation; 10 bits covers 3*255 + 255
    assign w_smooth = 8'(({2'b00, o_dark_max} * 10'd3 + {2'b00, w_cand_c}) >> 2);

    // The first estimate after reset is taken raw: smoothing toward A_INIT
    // would only drag the first few frames toward a meaningless value.
    assign w_new_dark_max = ((SMOOTH == 0) || !o_frame_valid) ? w_cand_c : w_smooth;

    // ------------------------------------------------------------------
    // Stage 1: min(R,G), hold B, delay stream
    // ------------------------------------------------------------------
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_m1    <= 8'd0;
            r_s1_b     <= 8'd0;
            r_s1_rgb   <= 24'd0;
            r_s1_hsync <= 1'b0;
            r_s1_vsync <= 1'b0;
            r_s1_de    <= 1'b0;
        end else begin
            r_s1_m1    <= w_m1;
            r_s1_b     <= w_b;
            r_s1_rgb   <= i_rgb;
            r_s1_hsync <= i_hsync;
            r_s1_vsync <= i_vsync;
            r_s1_de    <= i_de;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: dark channel
    // ------------------------------------------------------------------
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_dark  <= 8'd0;
            r_s2_rgb   <= 24'd0;
            r_s2_hsync <= 1'b0;
            r_s2_vsync <= 1'b0;
            r_s2_de    <= 1'b0;
        end else begin
            r_s2_dark  <= w_dark;
            r_s2_rgb   <= r_s1_rgb;
            r_s2_hsync <= r_s1_hsync;
            r_s2_vsync <= r_s1_vsync;
            r_s2_de    <= r_s1_de;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: dark * OMEGA; only the integer byte of the Q8 product is kept
    // ------------------------------------------------------------------
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_s3_prod_hi <= 8'd0;
            r_s3_rgb     <= 24'd0;
            r_s3_hsync   <= 1'b0;
            r_s3_vsync   <= 1'b0;
            r_s3_de      <= 1'b0;
        end else begin
            r_s3_prod_hi <= 8'((16'(r_s2_dark) * 16'(c_omega)) >> 8);
            r_s3_rgb     <= r_s2_rgb;
            r_s3_hsync   <= r_s2_hsync;
            r_s3_vsync   <= r_s2_vsync;
            r_s3_de      <= r_s2_de;
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: transmittance and output stream
    // ------------------------------------------------------------------
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            o_transmittance <= 8'd0;
            o_rgb           <= 24'd0;
            o_hsync         <= 1'b0;
            o_vsync         <= 1'b0;
            o_de            <= 1'b0;
        end else begin
            o_transmittance <= w_t_clamped;
            o_rgb           <= r_s3_rgb;
            o_hsync         <= r_s3_hsync;
            o_vsync         <= r_s3_vsync;
            o_de            <= r_s3_de;
        end
    end

    // ------------------------------------------------------------------
    // Frame maximum and atmospheric light latch
    // ------------------------------------------------------------------
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_max     <= 8'd0;
            r_has_pix     <= 1'b0;
            o_dark_max    <= c_a_init;
            o_frame_valid <= 1'b0;
        end else if (w_event) begin
            // Statistics restart for the new frame whether or not we latch
            r_run_max <= 8'd0;
            r_has_pix <= 1'b0;
            if (w_has) begin
                o_dark_max    <= w_new_dark_max;
                o_frame_valid <= 1'b1;
            end
        end else if (r_s2_de) begin
            r_run_max <= (r_s2_dark > r_run_max) ? r_s2_dark : r_run_max;
            r_has_pix <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fog_param_estimator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fog_param_estimator
//  Description : Directed self-checking bench for fog_param_estimator. Two
//                instances share the stimulus: one with SMOOTH=1 and one
//                with SMOOTH=0, each checked against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fog_param_estimator;

    logic        pixelclk;
    logic        reset_n;
    logic [23:0] i_rgb;
    logic        i_hsync;
    logic        i_vsync;
    logic        i_de;

    logic [23:0] s1_rgb, s0_rgb;
    logic [7:0]  s1_trans, s0_trans;
    logic [7:0]  s1_dm, s0_dm;
    logic        s1_hs, s0_hs, s1_vs, s0_vs, s1_de, s0_de, s1_fv, s0_fv;

    int n_vec = 0;
    int n_err = 0;

    fog_param_estimator #(.SMOOTH(1)) dut_s1 (
        .pixelclk        (pixelclk),
        .reset_n         (reset_n),
        .i_rgb           (i_rgb),
        .i_hsync         (i_hsync),
        .i_vsync         (i_vsync),
        .i_de            (i_de),
        .o_rgb           (s1_rgb),
        .o_transmittance (s1_trans),
        .o_dark_max      (s1_dm),
        .o_hsync         (s1_hs),
        .o_vsync         (s1_vs),
        .o_de            (s1_de),
        .o_frame_valid   (s1_fv)
    );

    fog_param_estimator #(.SMOOTH(0)) dut_s0 (
        .pixelclk        (pixelclk),
        .reset_n         (reset_n),
        .i_rgb           (i_rgb),
        .i_hsync         (i_hsync),
        .i_vsync         (i_vsync),
        .i_de            (i_de),
        .o_rgb           (s0_rgb),
        .o_transmittance (s0_trans),
        .o_dark_max      (s0_dm),
        .o_hsync         (s0_hs),
        .o_vsync         (s0_vs),
        .o_de            (s0_de),
        .o_frame_valid   (s0_fv)
    );

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic de, input logic vs, input logic hs);
        i_rgb   = {r, g, b};
        i_de    = de;
        i_vsync = vs;
        i_hsync = hs;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Single-cycle vsync pulse followed by the 3 cycles needed for the
    // latched value to appear.
    task automatic vsync_pulse();
        set_in(0, 0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        // Reset state
        check("rst_rgb",   s1_rgb,   0);
        check("rst_trans", s1_trans, 0);
        check("rst_de",    s1_de,    0);
        check("rst_hs",    s1_hs,    0);
        check("rst_vs",    s1_vs,    0);
        check("rst_dm_s1", s1_dm,    255);
        check("rst_dm_s0", s0_dm,    255);
        check("rst_fv_s1", s1_fv,    0);

        // Transmittance pipeline: three back-to-back pixels
        reset_n = 1'b1;
        set_in(200, 150, 100, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(255, 255, 255, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(0, 0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        check("p1_rgb",   s1_rgb,   24'hC89664);
        check("p1_de",    s1_de,    1);
        check("p1_hs",    s1_hs,    1);
        check("p1_trans", s1_trans, 161);
        check("p1_dm",    s1_dm,    255);
        check("p1_fv",    s1_fv,    0);
        tick();
        check("p2_rgb",   s1_rgb,   24'hFFFFFF);
        check("p2_hs",    s1_hs,    0);
        check("p2_trans", s1_trans, 26);
        tick();
        check("p3_trans", s1_trans, 255);
        check("p3_de",    s1_de,    1);
        tick();
        check("p4_de",    s1_de,    0);

        // Clear the statistics collected from the pixels above
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Frame 1: darks 40, 180, 90
        set_in(40, 200, 250, 1'b1, 1'b0, 1'b0);  tick();
        set_in(180, 181, 190, 1'b1, 1'b0, 1'b0); tick();
        set_in(255, 90, 120, 1'b1, 1'b0, 1'b0);  tick();
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        set_in(0, 0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check("f1_pre_dm", s1_dm, 255);
        tick();
        check("f1_dm_s1", s1_dm, 180);
        check("f1_dm_s0", s0_dm, 180);
        check("f1_fv_s1", s1_fv, 1);
        check("f1_vs_out", s1_vs, 0);
        tick();
        check("f1_vs_out2", s1_vs, 1);
        repeat (2) tick();
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();

        // Frame 2: max dark 100, below A_MIN
        set_in(100, 100, 100, 1'b1, 1'b0, 1'b0); tick();
        set_in(60, 70, 80, 1'b1, 1'b0, 1'b0);    tick();
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        vsync_pulse();
        check("f2_dm_s1", s1_dm, 167);
        check("f2_dm_s0", s0_dm, 128);
        repeat (4) tick();

        // Frame 3: max dark 50
        set_in(50, 60, 70, 1'b1, 1'b0, 1'b0); tick();
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        vsync_pulse();
        check("f3_dm_s1", s1_dm, 157);
        check("f3_dm_s0", s0_dm, 128);
        repeat (4) tick();

        // Frame with no de pixels: estimates hold
        vsync_pulse();
        repeat (3) tick();
        check("fe_dm_s1", s1_dm, 157);
        check("fe_dm_s0", s0_dm, 128);
        check("fe_fv_s1", s1_fv, 1);
        check("fe_fv_s0", s0_fv, 1);

        // Last pixel (dark 250) coincident with the vsync edge, prev max 200
        set_in(200, 210, 220, 1'b1, 1'b0, 1'b0); tick();
        set_in(250, 251, 252, 1'b1, 1'b1, 1'b0); tick();
        set_in(0, 0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check("co_dm_s0", s0_dm, 250);
        check("co_dm_s1", s1_dm, 180);
        repeat (1000) tick();
        check("hold_dm_s1", s1_dm, 180);
        check("hold_dm_s0", s0_dm, 250);
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("hold2_dm_s1", s1_dm, 180);

        // Mid-frame reset after a dark of 230
        set_in(230, 240, 250, 1'b1, 1'b0, 1'b0); tick();
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_dm_s1", s1_dm, 255);
        check("mr_dm_s0", s0_dm, 255);
        check("mr_fv_s1", s1_fv, 0);
        check("mr_trans", s1_trans, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        set_in(120, 130, 140, 1'b1, 1'b0, 1'b0); tick();
        set_in(10, 20, 30, 1'b1, 1'b0, 1'b0);    tick();
        set_in(0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        vsync_pulse();
        check("ar_dm_s1", s1_dm, 128);
        check("ar_dm_s0", s0_dm, 128);
        check("ar_fv_s1", s1_fv, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
